// File: rtl/serial_cmp_ctrl.sv
// Serial unsigned magnitude comparator: scans 2-bit digits MSB first, one per cycle.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN finishes on the first differing digit.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             gt,
  output logic             lt
);

  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             dec_q, dgt_q;
  logic             busy_q, done_q, equal_q, gt_q, lt_q;

  logic [WIDTH-1:0] a_sh_d, b_sh_d;
  logic [1:0]       da_d, db_d;
  logic             dig_ne_d, dig_gt_d, fin_dec_d, fin_gt_d, exit_d;

  assign a_sh_d   = a_q >> {idx_q, 1'b0};
  assign b_sh_d   = b_q >> {idx_q, 1'b0};
  assign da_d     = a_sh_d[1:0];
  assign db_d     = b_sh_d[1:0];
  assign dig_ne_d = (da_d != db_d);
  assign dig_gt_d = (da_d > db_d);

  // Once a digit has decided the outcome, later digits are only scanned, never used.
  assign fin_dec_d = dec_q | dig_ne_d;
  assign fin_gt_d  = dec_q ? dgt_q : dig_gt_d;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign exit_d = dig_ne_d || (idx_q == '0);
`else
  assign exit_d = (idx_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dec_q   <= 1'b0;
      dgt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= IW'(D - 1);
            dec_q   <= 1'b0;
            dgt_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (exit_d) begin
            equal_q <= ~fin_dec_d;
            gt_q    <= fin_dec_d & fin_gt_d;
            lt_q    <= fin_dec_d & ~fin_gt_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            dec_q <= fin_dec_d;
            dgt_q <= fin_gt_d;
            idx_q <= idx_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign equal = equal_q;
  assign gt    = gt_q;
  assign lt    = lt_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl (WIDTH=8): directed cases plus random operands against a
// reference model built from plain unsigned comparison and digit-position latency.
module tb_serial_cmp_ctrl;

  localparam int W = 8;
  localparam int D = W / 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, equal, gt, lt;

  int n_cmp;
  int n_fail;

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .equal (equal),
    .gt    (gt),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle in which done is expected, counting the start-sampling edge as edge 0.
  function automatic int exp_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
    int unsigned x, y;
    x = av;
    y = bv;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int k = 1; k <= D; k++) begin
      if (((x >> (2 * (D - k))) % 4) != ((y >> (2 * (D - k))) % 4)) return k + 1;
    end
`endif
    return D + 1;
  endfunction

  // One comparison. ign_cyc>0 injects a spurious start with other operands in that
  // cycle if still running. chain keeps start high and presents nav/nbv at done.
  // started=1 means the start was already accepted (chained from a previous op).
  task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int ign_cyc, input bit chain, input bit started,
                        input logic [W-1:0] nav, input logic [W-1:0] nbv);
    int  lat;
    bit  e_eq, e_gt, e_lt;
    lat  = exp_lat(av, bv);
    e_eq = (av == bv);
    e_gt = (av > bv);
    e_lt = (av < bv);
    if (!started) begin
      start = 1'b1;
      a     = av;
      b     = bv;
      tick();
    end
    for (int c = 1; c <= lat; c++) begin
      start = chain;
      a     = W'($urandom);
      b     = W'($urandom);
      if (c == ign_cyc && c < lat) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
      end
      n_cmp++;
      if (busy !== (c < lat)) begin
        n_fail++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", nm, c, busy, (c < lat));
      end
      n_cmp++;
      if (done !== (c == lat)) begin
        n_fail++;
        $display("FAIL %s done cyc=%0d got=%b want=%b", nm, c, done, (c == lat));
      end
      if (c == lat) begin
        n_cmp++;
        if ({equal, gt, lt} !== {e_eq, e_gt, e_lt}) begin
          n_fail++;
          $display("FAIL %s result a=%h b=%h got eq/gt/lt=%b%b%b want=%b%b%b",
                   nm, av, bv, equal, gt, lt, e_eq, e_gt, e_lt);
        end
        if (chain) begin
          a = nav;
          b = nbv;
        end
      end
      tick();
    end
    start = 1'b0;
    if (chain) begin
      n_cmp++;
      if ({busy, done} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s chain_restart got busy/done=%b%b want=10", nm, busy, done);
      end
    end else begin
      n_cmp++;
      if ({busy, done, equal, gt, lt} !== {2'b00, e_eq, e_gt, e_lt}) begin
        n_fail++;
        $display("FAIL %s after_done got b/d/eq/gt/lt=%b%b%b%b%b want=00%b%b%b",
                 nm, busy, done, equal, gt, lt, e_eq, e_gt, e_lt);
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = W'($urandom);
    b     = W'($urandom);
    tick();
    tick();
    n_cmp++;
    if ({busy, done, equal, gt, lt} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_state got b/d/eq/gt/lt=%b%b%b%b%b want=00000", busy, done, equal, gt, lt);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    n_cmp++;
    if ({busy, done, equal, gt, lt} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_idle got b/d/eq/gt/lt=%b%b%b%b%b want=00000", busy, done, equal, gt, lt);
    end
  endtask

  task automatic test_directed();
    run_op("eq_a5",   8'hA5, 8'hA5, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    run_op("gt_c0",   8'hC0, 8'h80, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_op("lt_4f",   8'h4F, 8'h80, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_op("lt_01",   8'h01, 8'h02, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_op("gt_ff",   8'hFF, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    run_op("eq_zero", 8'h00, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_ignore_start();
    run_op("ign_start", 8'h10, 8'h20, 2, 1'b0, 1'b0, 8'h00, 8'h00);
    run_op("ign_start_eq", 8'h3C, 8'h3C, 3, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_abort();
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, equal, gt, lt} !== 5'b00000) begin
      n_fail++;
      $display("FAIL abort_state got b/d/eq/gt/lt=%b%b%b%b%b want=00000", busy, done, equal, gt, lt);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_no_done i=%0d got busy/done=%b%b want=00", i, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first",  8'h55, 8'h55, 0, 1'b1, 1'b0, 8'h03, 8'h02);
    run_op("b2b_second", 8'h03, 8'h02, 0, 1'b0, 1'b1, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        run_op("rnd_chain", ra, rb, 0, 1'b1, 1'b0, rb, ra);
        run_op("rnd_chain2", rb, ra, 0, 1'b0, 1'b1, 8'h00, 8'h00);
      end else begin
        run_op("rnd", ra, rb, $urandom_range(0, D), 1'b0, 1'b0, 8'h00, 8'h00);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 2; digit count D = WIDTH/2.
REQ-002 Port: clk  input  1  single clock, all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to compare a and b; sampled only when the block is idle or done.
REQ-005 Port: a  input  WIDTH  operand A; sampled only on an accepted start.
REQ-006 Port: b  input  WIDTH  operand B; sampled only on an accepted start.
REQ-007 Port: busy  output  1  high while a comparison is in progress (RUN state).
REQ-008 Port: done  output  1  one-cycle pulse when a result is valid.
REQ-009 Port: equal  output  1  result: A == B.
REQ-010 Port: gt  output  1  result: A > B, unsigned.
REQ-011 Port: lt  output  1  result: A < B, unsigned.

Function
REQ-012 The block SHALL compare A and B serially, one 2-bit digit per cycle, MSB digit first, applying 2-bit comparator semantics per digit.
REQ-013 States SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: start=1 -> latch a, b into internal registers; digit index := D-1; go to RUN.
REQ-015 RUN: each cycle, compare the digit at the current index; if the digits are equal and the index > 0, decrement the index and stay in RUN.
REQ-016 RUN: the first differing digit decides the result (A digit > B digit -> gt, otherwise lt); later digits SHALL NOT change a decided result.
REQ-017 RUN: when index 0 has been evaluated and no digit differed, the result SHALL be equal.
REQ-018 RUN -> DONE: the result is registered onto equal/gt/lt in the same edge that enters DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1; start=1 in DONE is accepted per REQ-014 (back-to-back operation); otherwise the next state is IDLE.
REQ-020 start while in RUN SHALL be ignored; latched operands SHALL NOT change during RUN.
REQ-021 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-022 equal/gt/lt SHALL hold the last result until the next DONE entry; after the first completion, exactly one of them is 1.
REQ-023 Latency with the full scan (start sampled at edge 0): done SHALL be high in cycle D+1.
REQ-024 Input changes on a/b outside an accepted start SHALL have no effect.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, equal=0, gt=0, lt=0, and clear the digit index and operand registers.
REQ-026 rst SHALL take priority over start and over any in-progress RUN; an aborted comparison SHALL produce no done pulse.

Configuration
REQ-027 Macro SERIAL_CMP_EARLY_EXIT_EN defined: RUN SHALL go to DONE on the edge that evaluates the first differing digit; latency = m+1 cycles, where m = 1-based position (from the MSB) of the first differing digit, or D if A == B.
REQ-028 Macro SERIAL_CMP_EARLY_EXIT_EN undefined: RUN SHALL always evaluate all D digits (constant time, latency D+1 per REQ-023); the result is still decided by the first differing digit.

Verification (WIDTH=8, D=4; start is a 1-cycle pulse at edge 0)
REQ-029 a=0xA5, b=0xA5 -> done in cycle 5, equal=1, gt=0, lt=0 (both configurations).
REQ-030 a=0xC0, b=0x80 -> gt=1; done in cycle 2 with SERIAL_CMP_EARLY_EXIT_EN, in cycle 5 without it.
REQ-031 a=0x4F, b=0x80 -> lt=1 (MSB digit 01 < 10 overrides the larger low digits); a=0x01, b=0x02 -> lt=1, done in cycle 5 in both configurations.
REQ-032 Start a=0x10, b=0x20; a second start with a=0xFF, b=0x00 in cycle 2 while busy -> ignored; result lt=1.
REQ-033 rst=1 in cycle 2 of a RUN -> next cycle busy=0, done=0, equal=gt=lt=0; no done pulse follows.
REQ-034 start held high through DONE with new operands a=0x03, b=0x02 -> new RUN begins immediately (busy=1 the cycle after done); second result gt=1.
